// File: rtl/bbox_msg_pkg.sv
// Shared types and constants for the bounding-box message reader.
// Build option: BBOX_MSG_READER_ID_CHECK_EN adds the device-ID check states.
package bbox_msg_pkg;

`ifdef BBOX_MSG_READER_ID_CHECK_EN
    typedef enum logic [3:0] {
        IDLE, ST_RD, ST_CAP, ID_RD, ID_CAP, TL_RD, TL_CAP,
        BR_RD, BR_CAP, UPDATE, FLUSH, DEV_RD, DEV_CAP, DEAD
    } state_e;
`else
    typedef enum logic [3:0] {
        IDLE, ST_RD, ST_CAP, ID_RD, ID_CAP, TL_RD, TL_CAP,
        BR_RD, BR_CAP, UPDATE, FLUSH
    } state_e;
`endif

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_MSG    = 3'd1;
    localparam logic [2:0]  ADDR_ID     = 3'd2;
    localparam logic [31:0] FLUSH_CMD   = 32'h0000_0010;
    localparam logic [31:0] DEV_ID      = 32'h1234_EEE2;

    localparam int COORD_W   = 11;
    localparam int X_MSB     = 26;
    localparam int X_LSB     = 16;
    localparam int Y_MSB     = 10;
    localparam int Y_LSB     = 0;
    localparam int USEDW_MSB = 15;
    localparam int USEDW_LSB = 8;

    localparam logic [7:0] MSG_WORDS = 8'd3;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    function automatic logic pad_bad(input logic [31:0] w);
        return (w[31:27] != 5'd0) || (w[15:11] != 5'd0);
    endfunction

    function automatic coord_t decode(input logic [31:0] w);
        coord_t c;
        c.x = w[X_MSB:X_LSB];
        c.y = w[Y_MSB:Y_LSB];
        return c;
    endfunction

endpackage

// File: rtl/bbox_msg_reader.sv
// Polls an image-processor FIFO and latches complete bounding-box messages.
// Build option: BBOX_MSG_READER_ID_CHECK_EN enables the start-up device-ID check.
module bbox_msg_reader
    import bbox_msg_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter logic [31:0] MSG_ID        = 32'h0052_4242
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [2:0]         m_address,
    output logic               m_read,
    output logic               m_write,
    output logic [31:0]        m_writedata,
    input  logic [31:0]        m_readdata,
    output logic [COORD_W-1:0] bb_left,
    output logic [COORD_W-1:0] bb_top,
    output logic [COORD_W-1:0] bb_right,
    output logic [COORD_W-1:0] bb_bottom,
    output logic               bb_valid,
    output logic               bb_none,
    output logic               sync_err,
    output logic               dev_err
);

    localparam int CW = $clog2(POLL_INTERVAL + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(POLL_INTERVAL);

`ifdef BBOX_MSG_READER_ID_CHECK_EN
    localparam state_e START = DEV_RD;
`else
    localparam state_e START = IDLE;
`endif

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    coord_t             tl_q, tl_d, br_q, br_d;
    logic [COORD_W-1:0] left_q, top_q, right_q, bottom_q;
    logic               valid_q, none_q, sync_err_q;
    logic               upd, flush, dev_bad;

    always_comb begin
        state_d     = state_q;
        cnt_d       = CNT_INIT;
        tl_d        = tl_q;
        br_d        = br_q;
        m_address   = 3'd0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_writedata = 32'd0;
        upd         = 1'b0;
        flush       = 1'b0;
        dev_bad     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) state_d = ST_RD;
            end
            ST_RD: begin
                m_read    = 1'b1;
                m_address = ADDR_STATUS;
                state_d   = ST_CAP;
            end
            ST_CAP: begin
                if (m_readdata[USEDW_MSB:USEDW_LSB] >= MSG_WORDS)
                    state_d = ID_RD;
                else
                    state_d = IDLE;
            end
            ID_RD: begin
                m_read    = 1'b1;
                m_address = ADDR_MSG;
                state_d   = ID_CAP;
            end
            ID_CAP: state_d = (m_readdata == MSG_ID) ? TL_RD : FLUSH;
            TL_RD: begin
                m_read    = 1'b1;
                m_address = ADDR_MSG;
                state_d   = TL_CAP;
            end
            TL_CAP: begin
                tl_d    = decode(m_readdata);
                state_d = pad_bad(m_readdata) ? FLUSH : BR_RD;
            end
            BR_RD: begin
                m_read    = 1'b1;
                m_address = ADDR_MSG;
                state_d   = BR_CAP;
            end
            BR_CAP: begin
                br_d    = decode(m_readdata);
                state_d = pad_bad(m_readdata) ? FLUSH : UPDATE;
            end
            UPDATE: begin
                upd     = 1'b1;
                state_d = ST_RD;
            end
            FLUSH: begin
                m_write     = 1'b1;
                m_address   = ADDR_STATUS;
                m_writedata = FLUSH_CMD;
                flush       = 1'b1;
                tl_d        = '0;
                br_d        = '0;
                state_d     = IDLE;
            end
`ifdef BBOX_MSG_READER_ID_CHECK_EN
            DEV_RD: begin
                m_read    = 1'b1;
                m_address = ADDR_ID;
                state_d   = DEV_CAP;
            end
            DEV_CAP: begin
                dev_bad = (m_readdata != DEV_ID);
                state_d = dev_bad ? DEAD : IDLE;
            end
            DEAD: state_d = DEAD;
`endif
            default: state_d = START;
        endcase
    end

    // Coordinates only move on UPDATE so a box never mixes two messages.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= START;
            cnt_q      <= CNT_INIT;
            tl_q       <= '0;
            br_q       <= '0;
            left_q     <= '0;
            top_q      <= '0;
            right_q    <= '0;
            bottom_q   <= '0;
            valid_q    <= 1'b0;
            none_q     <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tl_q    <= tl_d;
            br_q    <= br_d;
            valid_q <= upd;
            if (upd) begin
                left_q   <= tl_q.x;
                top_q    <= tl_q.y;
                right_q  <= br_q.x;
                bottom_q <= br_q.y;
                none_q   <= (tl_q.x > br_q.x) || (tl_q.y > br_q.y);
            end
            if (flush) sync_err_q <= 1'b1;
        end
    end

`ifdef BBOX_MSG_READER_ID_CHECK_EN
    logic dev_err_q;

    always_ff @(posedge clk) begin
        if (!reset_n)     dev_err_q <= 1'b0;
        else if (dev_bad) dev_err_q <= 1'b1;
    end

    assign dev_err = dev_err_q;
`else
    assign dev_err = 1'b0;
`endif

    assign bb_left   = left_q;
    assign bb_top    = top_q;
    assign bb_right  = right_q;
    assign bb_bottom = bottom_q;
    assign bb_valid  = valid_q;
    assign bb_none   = none_q;
    assign sync_err  = sync_err_q;

endmodule

// File: doc/bbox_msg_reader.md
BBOX_MSG_READER -- requirements
Module: bbox_msg_reader

Interface
REQ-001 SHALL have parameter POLL_INTERVAL, default 1024, giving the number of idle cycles between status polls (minimum 1).
REQ-002 SHALL have parameter MSG_ID, default 32'h00524242 ("RBB"), the expected message-ID word.
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port m_address, output, 3, the register address of the image-processor slave.
REQ-006 SHALL have ports m_read and m_write, outputs, 1 each, read and write strobes.
REQ-007 SHALL have port m_writedata, output, 32, the write data.
REQ-008 SHALL have port m_readdata, input, 32, read data that is valid exactly one cycle after the m_read cycle.
REQ-009 SHALL have ports bb_left, bb_top, bb_right and bb_bottom, outputs, 11 each, the last accepted bounding box.
REQ-010 SHALL have port bb_valid, output, 1, a one-cycle pulse when a new box is latched.
REQ-011 SHALL have port bb_none, output, 1, high when the latched box has bb_left>bb_right or bb_top>bb_bottom (no object detected).
REQ-012 SHALL have port sync_err, output, 1, sticky and set on any malformed message.
REQ-013 SHALL have port dev_err, output, 1, the device-ID mismatch flag (see Configuration).

Function
REQ-014 SHALL implement the FSM states IDLE, ST_RD, ST_CAP, ID_RD, ID_CAP, TL_RD, TL_CAP, BR_RD, BR_CAP, UPDATE, FLUSH and DEAD.
REQ-015 SHALL keep IDLE for POLL_INTERVAL cycles using a down-counter, then go to ST_RD.
REQ-016 SHALL, in every *_RD state, assert m_read for exactly one cycle with m_address set; the next *_CAP state has m_read low and samples m_readdata, so a read is never asserted on consecutive cycles.
REQ-017 SHALL use addresses: status 0, message 1, device ID 2.
REQ-018 SHALL, in ST_CAP, go to ID_RD if m_readdata[15:8] >= 3, else to IDLE.
REQ-019 SHALL, in ID_CAP, go to TL_RD if the word equals MSG_ID, else to FLUSH.
REQ-020 SHALL, in TL_CAP and BR_CAP, decode x=word[26:16] and y=word[10:0]; if word[31:27] or word[15:11] is nonzero, go to FLUSH.
REQ-021 SHALL hold the decoded TL/BR values in shadow registers and copy all four coordinates to the outputs only in UPDATE, so the outputs never mix two messages.
REQ-022 SHALL, in UPDATE, assert bb_valid for one cycle, then return to ST_RD, draining back-to-back messages without waiting for the poll interval.
REQ-023 SHALL, in FLUSH, assert m_write for one cycle with m_address=0 and m_writedata=32'h00000010, set sync_err, discard the shadow registers, and go to IDLE.
REQ-024 SHALL make the latency from the ID_RD cycle to bb_valid exactly 7 cycles.
REQ-025 SHALL accept a box equal to 0 or 2047 on any axis without error.
REQ-026 SHALL drive m_read and m_write low, and m_address and m_writedata to 0, in all states where they are not asserted.

Reset
REQ-027 SHALL, while reset_n is low at a clock edge, force the FSM to its start state, clear all outputs, bb_none and sync_err, and load the poll counter with POLL_INTERVAL.
REQ-028 SHALL abort any read sequence when reset is applied mid-message and leave the outputs unchanged until the next full UPDATE.

Configuration
REQ-029 SHALL, with BBOX_MSG_READER_ID_CHECK_EN defined, start after reset with one read of address 2; if the value is 32'h1234EEE2 it goes to IDLE, otherwise it sets dev_err and stays in DEAD until reset with no bus activity.
REQ-030 SHALL, without BBOX_MSG_READER_ID_CHECK_EN, start in IDLE, tie dev_err to 0, and omit the DEAD state.

Structure
REQ-031 SHALL place the state enum, the address constants (status, message, ID), FLUSH_CMD=32'h10, DEV_ID=32'h1234EEE2 and the coordinate bit-field positions in the shared package bbox_msg_pkg.
REQ-032 SHALL have no sub-modules; the poll counter and FSM are inline.

Verification
REQ-033 SHALL verify that a status read returning usedw=3 followed by words 00524242, 00640032 and 01F401C2 gives bb_valid with L=100, T=50, R=500, B=450 and bb_none=0.
REQ-034 SHALL verify that an ID word of 00414141 causes one write of 0x10 to address 0, sets sync_err, and produces no bb_valid.
REQ-035 SHALL verify that a TL word of 08000000 (pad bit set) causes a flush and leaves the previous box unchanged.
REQ-036 SHALL verify that a message of 027F01DF then 00000000 latches L=639, T=479, R=0, B=0 with bb_none=1.
REQ-037 SHALL verify that usedw=6 gives two consecutive messages with two bb_valid pulses, without returning to IDLE in between.
REQ-038 SHALL verify, with ID_CHECK_EN defined, that an ID read returning 0 sets dev_err and produces no further m_read; and that reset asserted during TL_CAP gives a clean restart.
